// File: rtl/spi_xform_pkg.sv
// Shared types and word transform for the SPI transform slave.
// Holds the FSM state enum, mode encodings and the combinational xform().
package spi_xform_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    TX,
    DONE
  } state_t;

  localparam logic [1:0] MODE_REV   = 2'b00;
  localparam logic [1:0] MODE_ECHO  = 2'b01;
  localparam logic [1:0] MODE_INV   = 2'b10;
  localparam logic [1:0] MODE_NSWAP = 2'b11;

  // Operates on the low 'width' bits of w; callers truncate the result.
  // Nibble swap walks whole bytes from the MSB end, so a partial
  // byte left over at the LSB end passes through untouched.
  function automatic logic [31:0] xform(
    input logic [1:0]  m,
    input logic [31:0] w,
    input int          width
  );
    logic [31:0] r;
    int          pos;
    r = w;
    case (m)
      MODE_REV: begin
        r = '0;
        for (int i = 0; i < 32; i++)
          if (i < width) r[i] = w[width-1-i];
      end
      MODE_ECHO: r = w;
      MODE_INV:  r = ~w;
      default: begin
        for (int b = 0; b < 4; b++)
          if (8*b + 8 <= width) begin
            pos = width - 8*b - 8;
            r[pos +: 8] = {w[pos +: 4], w[pos+4 +: 4]};
          end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchronizer for sck/ss/mosi plus sck rise/fall detection.
// Ports: clock, reset (async low), sck/ss/mosi in; ss_s, mosi_s, sck_rise, sck_fall out.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic ss_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall
);

  logic [STAGES-1:0] sck_q;
  logic [STAGES-1:0] ss_q;
  logic [STAGES-1:0] mosi_q;
  logic              sck_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_q  <= '0;
      ss_q   <= '1;
      mosi_q <= '1;
      sck_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[STAGES-2:0], sck};
      ss_q   <= {ss_q[STAGES-2:0], ss};
      mosi_q <= {mosi_q[STAGES-2:0], mosi};
      sck_d  <= sck_q[STAGES-1];
    end
  end

  assign ss_s     = ss_q[STAGES-1];
  assign mosi_s   = mosi_q[STAGES-1];
  assign sck_rise = sck_q[STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[STAGES-1] & sck_d;

endmodule

// File: rtl/spi_xform_slave.sv
// SPI mode-0 slave: receives a WIDTH-bit word, returns its transform.
// Ports: clock, reset (async low), sck, ss, mosi, mode -> miso, rx_data,
// rx_valid, busy, err. Optional macro SPI_XFORM_OVERRUN_EN enables err.
module spi_xform_slave
  import spi_xform_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  input  logic [1:0]       mode,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             err
);

  localparam int         CW   = $clog2(WIDTH + 1);
  localparam logic [1:0] WARM = 2'(SYNC_STAGES);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             ss_s;
  logic             mosi_s;
  logic             sck_rise;
  logic             sck_fall;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] result;
  logic [1:0]       mode_q;
  logic [1:0]       warm;
  logic             armed;
  logic [WIDTH-1:0] word;

  spi_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .sck     (sck),
    .ss      (ss),
    .mosi    (mosi),
    .ss_s    (ss_s),
    .mosi_s  (mosi_s),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall)
  );

  assign word = {shreg, mosi_s};
  assign busy = (state == RX) || (state == TX);

  // The sync chain resets to ss=1, so a real high ss is only trusted
  // once the chain has flushed (warm); this forces an ss toggle after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      result   <= '0;
      mode_q   <= MODE_REV;
      warm     <= '0;
      armed    <= 1'b0;
      miso     <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (warm != WARM) warm <= warm + 2'd1;
      if (ss_s) begin
        state <= IDLE;
        cnt   <= '0;
        miso  <= 1'b1;
        if (warm == WARM) armed <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (armed) begin
              mode_q <= mode;
              cnt    <= '0;
              state  <= RX;
            end
          end
          RX: begin
            if (sck_rise) begin
              shreg <= word[WIDTH-2:0];
              if (cnt == LAST) begin
                rx_data  <= word;
                rx_valid <= 1'b1;
                result   <= WIDTH'(xform(mode_q, 32'(word), WIDTH));
                cnt      <= '0;
                state    <= TX;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          TX: begin
            if (sck_fall) begin
              miso   <= result[WIDTH-1];
              result <= result << 1;
            end
            if (sck_rise) begin
              if (cnt == LAST) begin
                cnt   <= '0;
                miso  <= 1'b1;
                state <= DONE;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          DONE: miso <= 1'b1;
        endcase
      end
    end
  end

`ifdef SPI_XFORM_OVERRUN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (ss_s)
      err <= 1'b0;
    else if (state == DONE && sck_rise)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/spi_xform_slave.md
SPI_XFORM_SLAVE -- requirements
Module: spi_xform_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame word width in bits (legal 4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sck/ss/mosi (legal 2..3).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sck  input  1  SPI serial clock, asynchronous to clock, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port ss  input  1  slave select, active-low; high aborts any frame.
REQ-007 SHALL have port mosi  input  1  serial data in, MSB first.
REQ-008 SHALL have port mode  input  2  transform: 00 bit-reverse, 01 echo, 10 invert, 11 nibble-swap of each byte.
REQ-009 SHALL have port miso  output  1  serial data out, MSB first; idles at 1.
REQ-010 SHALL have port rx_data  output  WIDTH  last complete received word.
REQ-011 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 SHALL have port busy  output  1  high in RX or TX.
REQ-013 SHALL have port err  output  1  sticky overrun flag (see Configuration).

Function
REQ-014 SHALL pass sck, ss, mosi through SYNC_STAGES flops before use; sck rise/fall SHALL be detected from the synchronized value.
REQ-015 SHALL require sck high and low phases of at least SYNC_STAGES+2 clock cycles; behaviour outside this is undefined.
REQ-016 SHALL implement states IDLE, RX, TX, DONE.
REQ-017 IDLE: on synchronized ss low SHALL latch mode into mode_q, clear bit counter, go RX.
REQ-018 RX: each sck rise SHALL shift synchronized mosi into the LSB of the shift register and increment the counter.
REQ-019 On the WIDTH-th RX rise SHALL load rx_data, pulse rx_valid one cycle, compute result = transform(mode_q, word), go TX, counter cleared.
REQ-020 Transform SHALL be purely combinational on the full WIDTH; nibble-swap SHALL leave a trailing partial byte (WIDTH not multiple of 8) unchanged.
REQ-021 TX: on the first sck fall SHALL drive miso = result[WIDTH-1]; each later fall SHALL drive the next lower bit.
REQ-022 TX: each sck rise SHALL increment the counter; on the WIDTH-th rise SHALL go DONE.
REQ-023 DONE: miso SHALL be 1; state held until ss high.
REQ-024 In IDLE, RX, DONE miso SHALL be 1.
REQ-025 Synchronized ss high in any state SHALL force IDLE, miso 1, counter 0 on the next cycle, no rx_valid.
REQ-026 ss high and an sck edge in the same cycle: ss SHALL win, edge ignored.
REQ-027 mode changes after frame start SHALL not affect the current frame.
REQ-028 busy SHALL be 1 exactly in RX and TX.

Reset
REQ-029 reset low SHALL asynchronously force state IDLE, miso 1, rx_data 0, rx_valid 0, busy 0, err 0, counter 0, shift register 0, synchronizer flops to sck=0, ss=1, mosi=1.
REQ-030 Reset mid-frame SHALL abort; after release the block SHALL wait in IDLE until ss is seen high and then low again.

Configuration
REQ-031 Macro SPI_XFORM_OVERRUN_EN defined: any sck rise in DONE SHALL set err, held until ss high or reset.
REQ-032 Macro undefined: err SHALL be constant 0 and no detection logic built.

Structure
REQ-033 Package spi_xform_pkg SHALL hold the state enum, the mode encoding constants and the transform function.
REQ-034 Sub-module spi_sync SHALL hold the synchronizer and sck rise/fall detector; one instance.

Verification
REQ-035 WIDTH=8, mode 00, send 0x01 then 8 dummy clocks -> rx_data 0x01 with one rx_valid pulse, miso returns 0x80, DONE, miso 1.
REQ-036 WIDTH=8, mode 10, send 0xA5 -> miso returns 0x5A; mode 01 send 0x3C -> returns 0x3C.
REQ-037 WIDTH=16, mode 11, send 0x1234 -> returns 0x2143; WIDTH=12, mode 11, send 0xABC -> returns 0xBAC.
REQ-038 ss high after 4 RX bits -> IDLE within SYNC_STAGES+1 cycles, no rx_valid, miso 1; next frame 0x0F mode 00 returns 0xF0.
REQ-039 reset low mid-TX -> all outputs at reset values immediately; frame after ss toggle completes correctly.
REQ-040 With SPI_XFORM_OVERRUN_EN: 17 sck clocks at WIDTH=8 -> err 1 after the 17th rise, clears when ss high; without macro err stays 0.
